// File: rtl/fifo_flow_if.sv
// fifo_flow_if: push/pop handshake and status bundle for fifo_flow.
// master drives push/data_in/pop; slave (the FIFO) drives data and flags.
interface fifo_flow_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  alm_full;
    logic                  alm_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  fifo_error;

    modport master (
        output push, data_in, pop,
        input  data_out, empty, full, alm_full, alm_empty, count, fifo_error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, empty, full, alm_full, alm_empty, count, fifo_error
    );
endinterface

// File: rtl/fifo_flow.sv
// fifo_flow: single-clock FIFO with registered read data and count-decoded flags.
// Ports: clk, rst (async active-low), bus (fifo_flow_if.slave: push/pop/data/status).
module fifo_flow #(
    parameter int DATA_WIDTH   = 10,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALM_FULL_TH  = 6,
    parameter int ALM_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_flow_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALM_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALM_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic ovf;
    logic unf;

    // Flags come only from the registered count, so no push/pop path to outputs.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign pop_ok  = bus.pop & ~empty;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign push_ok = bus.push & (~full | pop_ok);
    assign ovf     = bus.push & full & ~pop_ok;
    assign unf     = bus.pop & empty;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ovf | unf)
                err_q <= 1'b1;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.alm_full   = (count_q >= AF_C);
    assign bus.alm_empty  = (count_q <= AE_C);
    assign bus.count      = count_q;
    assign bus.fifo_error = err_q;
endmodule

// File: tb/tb_fifo_flow.sv
// tb_fifo_flow: directed plan plus random traffic checked against a queue model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_fifo_flow;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_flow_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

    fifo_flow #(
        .DATA_WIDTH(10), .ADDR_WIDTH(3),
        .ALM_FULL_TH(6), .ALM_EMPTY_TH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] q[$];
    logic [9:0] m_dout = '0;
    logic       m_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"},      32'(bus.count),      32'(sz));
        chk({tag, ".empty"},      32'(bus.empty),      32'(sz == 0));
        chk({tag, ".full"},       32'(bus.full),       32'(sz == 8));
        chk({tag, ".alm_full"},   32'(bus.alm_full),   32'(sz >= 6));
        chk({tag, ".alm_empty"},  32'(bus.alm_empty),  32'(sz <= 2));
        chk({tag, ".data_out"},   32'(bus.data_out),   32'(m_dout));
        chk({tag, ".fifo_error"}, 32'(bus.fifo_error), 32'(m_err));
    endtask

    // One clock: apply inputs, advance the model by the FIFO's rules, check.
    task automatic step(input string tag, input logic p, input logic [9:0] d,
                        input logic r);
        bit pok, wok;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = r;
        @(posedge clk);
        pok = r && (q.size() > 0);
        wok = p && (q.size() < 8 || pok);
        if (r && q.size() == 0) m_err = 1'b1;
        if (p && q.size() == 8 && !pok) m_err = 1'b1;
        if (pok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        q.delete();
        m_dout = '0;
        m_err  = 1'b0;
        check_all(tag);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        #12;
        check_all("reset");
        #4;
        rst = 1'b1;
        step("idle", 1'b0, 10'h000, 1'b0);

        for (int i = 1; i <= 8; i++)
            step("fill", 1'b1, 10'(i), 1'b0);
        step("ovf", 1'b1, 10'h3FF, 1'b0);
        for (int i = 0; i < 8; i++)
            step("drain", 1'b0, 10'h000, 1'b1);
        step("unf", 1'b0, 10'h000, 1'b1);

        do_reset("rst1");
        step("pp_empty", 1'b1, 10'h2A5, 1'b1);
        step("pp_empty_rd", 1'b0, 10'h000, 1'b1);

        for (int i = 0; i < 8; i++)
            step("fill2", 1'b1, 10'(10'h040 + i), 1'b0);
        step("pp_full", 1'b1, 10'h155, 1'b1);
        for (int i = 0; i < 8; i++)
            step("drain2", 1'b0, 10'h000, 1'b1);
        chk("wrap_last", 32'(bus.data_out), 32'h155);

        for (int i = 0; i < 5; i++)
            step("burst", 1'b1, 10'(10'h0A0 + i), 1'b0);
        bus.push = 1'b1;
        #2;
        do_reset("async_rst");
        step("post_push", 1'b1, 10'h0F0, 1'b0);
        step("post_pop", 1'b0, 10'h000, 1'b1);
        chk("post_val", 32'(bus.data_out), 32'h0F0);

        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i % 100 < 50) ? 70 : 30;
            step("rand", ($urandom % 100) < bias, 10'($urandom),
                 ($urandom % 100) < (100 - bias));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_flow.md
Name: fifo_flow

Overview:
- Synchronous single-clock FIFO that sits on both sides of the 4x4 routing arbiter: four instances on the ingress side and four on the egress side.
- The ingress FIFOs answer the arbiter's pop requests and supply popped words. The egress FIFOs accept its pushes.
- It provides the empty and almost-full status the arbiter uses for strict-priority scheduling and backpressure.
- Read data is registered. A word popped in cycle t is valid on data_out from the edge that ends cycle t, so the arbiter samples it one cycle after asserting pop.

Parameters:
- DATA_WIDTH, 10, word width; bits [9:8] carry the destination port.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries.
- ALM_FULL_TH, 6, alm_full asserted when count >= ALM_FULL_TH.
- ALM_EMPTY_TH, 2, alm_empty asserted when count <= ALM_EMPTY_TH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- push  input  1  write request; data_in is written when the push is accepted.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- alm_full  output  1  count >= ALM_FULL_TH.
- alm_empty  output  1  count <= ALM_EMPTY_TH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- fifo_error  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst low, asynchronous), regardless of clk:
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0, fifo_error = 0.
  - empty = 1, alm_empty = 1, full = 0, alm_full = 0.
  - Storage array is not reset.
  - Deasserting rst takes effect at the next rising edge. Reset mid-operation discards all contents.
- Pop acceptance:
  - pop_ok = pop & !empty.
  - On an accepted pop: data_out <= mem[rd_ptr], rd_ptr increments modulo DEPTH.
  - data_out holds its value when no pop is accepted.
- Push acceptance:
  - push_ok = push & (!full | pop_ok).
  - On an accepted push: mem[wr_ptr] <= data_in, wr_ptr increments modulo DEPTH.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Status flags:
  - All flags are decoded from the registered count. They are stable within a cycle and change only after an edge.
  - No combinational path exists from push/pop to any output.
- Simultaneous push and pop:
  - When empty: the push is accepted, the pop is ignored (no bypass). data_out unchanged; count becomes 1.
  - When full: both are accepted. The oldest word goes to data_out, the new word is written, count stays DEPTH.
  - Otherwise: both are accepted, count unchanged.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full versus empty is resolved by count, not by pointer equality.
- Errors:
  - push & full & !pop_ok: overflow; the write is dropped and fifo_error <= 1.
  - pop & empty: underflow; the read is dropped, data_out holds, fifo_error <= 1.
  - fifo_error clears only on reset.
- Latency:
  - Write to first-readable is 1 cycle: empty deasserts the cycle after the push edge.
  - Pop to data_out valid is 1 edge.

Test Plan:
- Reset then idle -> empty=1, alm_empty=1, full=0, alm_full=0, count=0, data_out=0, fifo_error=0.
- Push 0x001..0x008 on 8 consecutive cycles -> count reaches 8, full=1. alm_full rises after the 6th push; alm_empty falls after the 3rd push. A 9th push (0x3FF) -> fifo_error=1, count stays 8.
- Pop 8 times back-to-back from full -> data_out = 0x001..0x008 in order, one per edge, and empty=1 after the 8th. A further pop -> data_out holds 0x008, fifo_error=1.
- Push+pop together when empty with data_in=0x2A5 -> count=1, data_out unchanged. Next pop -> data_out=0x2A5.
- Fill to 8, then push 0x155 + pop together -> data_out = oldest word, count=8, no error. Drain all 8 -> the last word is 0x155, confirming pointer wrap.
- Assert rst low asynchronously mid-burst with count=5 -> all outputs return to reset values immediately, without a clock edge. After release, push 0x0F0 then pop -> data_out=0x0F0.
